// File: rtl/dac_pkg.sv
// Shared constants for the DAC playback controller: FSM encodings and default widths.
package dac_pkg;

   localparam int DAC_W      = 14;
   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DIV_W  = 16;
   localparam int DEF_CNT_W  = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/dac_playback_ctrl_lat_delay.sv
// Fixed-depth 1-bit shift register that re-times the BRAM read strobe into the
// DAC capture enable; cleared only by reset so it drains after stop/done.
module lat_delay #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_din,
   output logic o_dout
);

   logic [DEPTH-1:0] r_sh;

   generate
      if (DEPTH == 1) begin : g_single
         always_ff @(posedge clk) begin
            if (rst) r_sh <= '0;
            else     r_sh <= i_din;
         end
      end else begin : g_multi
         always_ff @(posedge clk) begin
            if (rst) r_sh <= '0;
            else     r_sh <= {r_sh[DEPTH-2:0], i_din};
         end
      end
   endgenerate

   assign o_dout = r_sh[DEPTH-1];

endmodule

// File: rtl/dac_playback_ctrl.sv
// Waveform playback sequencer: walks a BRAM address range at a programmable
// sample rate and emits a latency-aligned DAC capture enable.
module dac_playback_ctrl
   import dac_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DIV_W   = DEF_DIV_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cfg_start_addr,
   input  logic [ADDR_W-1:0] cfg_end_addr,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [CNT_W-1:0]  cfg_cycles,
   input  logic              cfg_trig_en,
   input  logic              start,
   input  logic              stop,
   input  logic              trig,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   output logic              dac_enable,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_start;
   logic [ADDR_W-1:0] r_end;
   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  r_div_max;
   logic [CNT_W-1:0]  r_rep;
   logic [CNT_W-1:0]  r_cycles;
   logic              r_done;
   logic              r_cfg_err;

   logic              w_tick;
   logic              w_last_pass;

   assign w_tick      = (r_state == ST_RUN) && (r_div == '0);
   assign w_last_pass = (r_cycles != '0) && ((r_rep + 1'b1) == r_cycles);

   // Counters are primed at start so a trigger-armed run enters RUN ready to fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_start   <= '0;
         r_end     <= '0;
         r_div     <= '0;
         r_div_max <= '0;
         r_rep     <= '0;
         r_cycles  <= '0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && !stop) begin
                  if (cfg_start_addr > cfg_end_addr) begin
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_start   <= cfg_start_addr;
                     r_end     <= cfg_end_addr;
                     r_div_max <= cfg_div;
                     r_cycles  <= cfg_cycles;
                     r_addr    <= cfg_start_addr;
                     r_div     <= '0;
                     r_rep     <= '0;
                     r_state   <= cfg_trig_en ? ST_ARM : ST_RUN;
                  end
               end
            end
            ST_ARM: begin
               if (stop)      r_state <= ST_IDLE;
               else if (trig) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (stop) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_div <= (r_div == r_div_max) ? '0 : r_div + 1'b1;
                  // On the final pass the address is left on end_addr so IDLE shows the last sample fetched.
                  if (w_tick) begin
                     if (r_addr == r_end) begin
                        if (w_last_pass) begin
                           r_state <= ST_IDLE;
                           r_done  <= 1'b1;
                        end else begin
                           r_addr <= r_start;
                           if (r_cycles != '0) r_rep <= r_rep + 1'b1;
                        end
                     end else begin
                        r_addr <= r_addr + 1'b1;
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   lat_delay #(
      .DEPTH (MEM_LAT)
   ) u_lat_delay (
      .clk    (clk),
      .rst    (rst),
      .i_din  (w_tick),
      .o_dout (dac_enable)
   );

   assign mem_addr = r_addr;
   assign mem_en   = w_tick;
   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;
   assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed bench for dac_playback_ctrl: vector tables for the cycle-exact
// sequences plus hand-written trigger, continuous/stop and reset cases.
module tb_dac_playback_ctrl;

   localparam int ADDR_W  = 14;
   localparam int DIV_W   = 16;
   localparam int CNT_W   = 16;
   localparam int MEM_LAT = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] cfgStartAddr;
   logic [ADDR_W-1:0] cfgEndAddr;
   logic [DIV_W-1:0]  cfgDiv;
   logic [CNT_W-1:0]  cfgCycles;
   logic              cfgTrigEn;
   logic              startIn;
   logic              stopIn;
   logic              trigIn;
   logic [ADDR_W-1:0] memAddr;
   logic              memEn;
   logic              dacEnable;
   logic              busyOut;
   logic              doneOut;
   logic              cfgErr;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic start;
      logic stop;
      logic trig;
      logic eMem;
      int   eAddr;
      logic eDac;
      logic eBusy;
      logic eDone;
      logic eErr;
   } vec_t;

   vec_t vecs[$];

   dac_playback_ctrl #(
      .ADDR_W  (ADDR_W),
      .DIV_W   (DIV_W),
      .CNT_W   (CNT_W),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_start_addr (cfgStartAddr),
      .cfg_end_addr   (cfgEndAddr),
      .cfg_div        (cfgDiv),
      .cfg_cycles     (cfgCycles),
      .cfg_trig_en    (cfgTrigEn),
      .start          (startIn),
      .stop           (stopIn),
      .trig           (trigIn),
      .mem_addr       (memAddr),
      .mem_en         (memEn),
      .dac_enable     (dacEnable),
      .busy           (busyOut),
      .done           (doneOut),
      .cfg_err        (cfgErr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic setCfg(input int s, input int e, input int d, input int c, input logic t);
      cfgStartAddr = ADDR_W'(s);
      cfgEndAddr   = ADDR_W'(e);
      cfgDiv       = DIV_W'(d);
      cfgCycles    = CNT_W'(c);
      cfgTrigEn    = t;
   endtask

   function automatic vec_t mk(input logic s, input logic p, input logic t, input logic m,
                               input int a, input logic dc, input logic b, input logic dn,
                               input logic er);
      vec_t v;
      v.start = s; v.stop = p; v.trig = t; v.eMem = m; v.eAddr = a;
      v.eDac = dc; v.eBusy = b; v.eDone = dn; v.eErr = er;
      return v;
   endfunction

   // Drives one row's inputs across a clock edge, then releases the pulses.
   task automatic applyStimulus(input vec_t v);
      startIn = v.start;
      stopIn  = v.stop;
      trigIn  = v.trig;
      stepCycle();
      startIn = 1'b0;
      stopIn  = 1'b0;
   endtask

   task automatic runTable(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("%s[%0d].mem_en", tag, i), int'(memEn), int'(vecs[i].eMem));
         checkOutput($sformatf("%s[%0d].dac_enable", tag, i), int'(dacEnable), int'(vecs[i].eDac));
         checkOutput($sformatf("%s[%0d].busy", tag, i), int'(busyOut), int'(vecs[i].eBusy));
         checkOutput($sformatf("%s[%0d].done", tag, i), int'(doneOut), int'(vecs[i].eDone));
         checkOutput($sformatf("%s[%0d].cfg_err", tag, i), int'(cfgErr), int'(vecs[i].eErr));
         if (vecs[i].eAddr >= 0)
            checkOutput($sformatf("%s[%0d].mem_addr", tag, i), int'(memAddr), vecs[i].eAddr);
      end
      vecs.delete();
      trigIn = 1'b0;
   endtask

   initial begin
      rst = 1'b1; startIn = 1'b0; stopIn = 1'b0; trigIn = 1'b0;
      setCfg(0, 0, 0, 0, 1'b0);
      stepCycle();
      stepCycle();
      checkOutput("reset.mem_addr", int'(memAddr), 0);
      checkOutput("reset.mem_en", int'(memEn), 0);
      checkOutput("reset.dac_enable", int'(dacEnable), 0);
      checkOutput("reset.busy", int'(busyOut), 0);
      checkOutput("reset.done", int'(doneOut), 0);
      checkOutput("reset.cfg_err", int'(cfgErr), 0);
      rst = 1'b0;
      stepCycle();

      $display("[TB] one-shot single pass");
      setCfg(0, 3, 0, 1, 1'b0);
      //              st p  t  mem addr dac busy done err
      vecs.push_back(mk(1, 0, 0, 1,  0,  0,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 1,  1,  1,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 1,  2,  1,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 1,  3,  1,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 0,  3,  1,  0,  1,  0));
      vecs.push_back(mk(0, 0, 0, 0,  3,  0,  0,  0,  0));
      runTable("oneshot");

      $display("[TB] divider and repetition, start while running");
      setCfg(10, 11, 2, 2, 1'b0);
      vecs.push_back(mk(1, 0, 0, 1, 10,  0,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 0, 11,  1,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 0, 11,  0,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 1, 11,  0,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 0, 10,  1,  1,  0,  0));
      vecs.push_back(mk(1, 0, 0, 0, 10,  0,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 1, 10,  0,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 0, 11,  1,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 0, 11,  0,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 1, 11,  0,  1,  0,  0));
      vecs.push_back(mk(0, 0, 0, 0, 11,  1,  0,  1,  0));
      vecs.push_back(mk(0, 0, 0, 0, 11,  0,  0,  0,  0));
      runTable("divrep");

      $display("[TB] rejected start and start/stop precedence");
      setCfg(5, 2, 0, 1, 1'b0);
      vecs.push_back(mk(1, 0, 0, 0, -1,  0,  0,  0,  1));
      vecs.push_back(mk(0, 0, 0, 0, -1,  0,  0,  0,  0));
      runTable("cfgerr");
      setCfg(0, 3, 0, 1, 1'b0);
      vecs.push_back(mk(1, 1, 0, 0, -1,  0,  0,  0,  0));
      vecs.push_back(mk(0, 0, 0, 0, -1,  0,  0,  0,  0));
      runTable("startstop");

      $display("[TB] trigger");
      begin
         bit seenDone = 1'b0;
         setCfg(0, 3, 0, 1, 1'b1);
         vecs.push_back(mk(1, 0, 0, 0, -1,  0,  1,  0,  0));
         runTable("arm");
         for (int i = 0; i < 20; i++) begin
            stepCycle();
            checkOutput($sformatf("armed[%0d].mem_en", i), int'(memEn), 0);
            checkOutput($sformatf("armed[%0d].busy", i), int'(busyOut), 1);
         end
         trigIn = 1'b1;
         stepCycle();
         trigIn = 1'b0;
         checkOutput("trig.first_mem_en", int'(memEn), 1);
         checkOutput("trig.first_addr", int'(memAddr), 0);
         for (int i = 0; i < 20 && !seenDone; i++) begin
            stepCycle();
            if (doneOut) seenDone = 1'b1;
         end
         checkOutput("trig.done_within_bound", int'(seenDone), 1);
         stepCycle();
         stepCycle();
      end

      $display("[TB] continuous with stop");
      begin
         int doneSeen = 0;
         setCfg(0, 7, 0, 0, 1'b0);
         startIn = 1'b1;
         stepCycle();
         startIn = 1'b0;
         for (int k = 1; k <= 30; k++) begin
            if (k > 1) stepCycle();
            checkOutput($sformatf("cont[%0d].mem_addr", k), int'(memAddr), (k - 1) % 8);
            checkOutput($sformatf("cont[%0d].mem_en", k), int'(memEn), 1);
            if (doneOut) doneSeen++;
         end
         stopIn = 1'b1;
         stepCycle();
         stopIn = 1'b0;
         if (doneOut) doneSeen++;
         checkOutput("stop.mem_en", int'(memEn), 0);
         checkOutput("stop.busy", int'(busyOut), 0);
         checkOutput("stop.trailing_dac", int'(dacEnable), 1);
         stepCycle();
         if (doneOut) doneSeen++;
         checkOutput("stop.dac_drained", int'(dacEnable), 0);
         checkOutput("stop.no_done", doneSeen, 0);
      end

      $display("[TB] reset mid-run");
      setCfg(0, 9, 0, 0, 1'b0);
      startIn = 1'b1;
      stepCycle();
      startIn = 1'b0;
      for (int k = 0; k < 6; k++) stepCycle();
      checkOutput("midrun.addr_before_reset", int'(memAddr), 6);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("midrun.mem_addr", int'(memAddr), 0);
      checkOutput("midrun.mem_en", int'(memEn), 0);
      checkOutput("midrun.dac_enable", int'(dacEnable), 0);
      checkOutput("midrun.busy", int'(busyOut), 0);
      checkOutput("midrun.done", int'(doneOut), 0);
      stepCycle();
      checkOutput("midrun.idle_busy", int'(busyOut), 0);
      checkOutput("midrun.idle_dac", int'(dacEnable), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
